// File: rtl/compare_seq_ctrl_if.sv
// Request/result and comparator-pin bundle for compare_seq_ctrl.
// slave = sequencer view, master = requester plus comparator view.
interface compare_seq_ctrl_if #(
    parameter int WORDS = 4
);
    logic                 Start;
    logic [8*WORDS-1:0]   OpA;
    logic [8*WORDS-1:0]   OpB;
    logic                 Busy;
    logic                 Done;
    logic                 ResEQ;
    logic                 ResGT;
    logic                 ResLT;
    logic                 ResErr;
    logic [7:0]           CmpA;
    logic [7:0]           CmpB;
    logic                 QAEB;
    logic                 QAGB;
    logic                 QASB;
    logic                 DbgState;

    // Start is level-sampled only while idle (Busy=0). Done is a one-cycle
    // pulse with Busy=0, and Res* stay valid until the next Done.
    modport slave (
        input  Start, OpA, OpB, QAEB, QAGB, QASB,
        output Busy, Done, ResEQ, ResGT, ResLT, ResErr, CmpA, CmpB, DbgState
    );

    modport master (
        output Start, OpA, OpB, QAEB, QAGB, QASB,
        input  Busy, Done, ResEQ, ResGT, ResLT, ResErr, CmpA, CmpB, DbgState
    );
endinterface

// File: rtl/compare_seq_ctrl.sv
// Byte-serial operand compare, MSB byte first, using one external 8-bit comparator.
// Optional macro SIGNED_CMP_EN selects a two's-complement compare.
module compare_seq_ctrl #(
    parameter int WORDS = 4,
    parameter int IDXW  = 4
) (
    input  logic               CLK,
    input  logic               RST,
    compare_seq_ctrl_if.slave  bus
);
    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t             state_q;
    logic [IDXW-1:0]    idx_q;
    logic [8*WORDS-1:0] reg_a_q;
    logic [8*WORDS-1:0] reg_b_q;
    logic               busy_q;
    logic               done_q;
    logic               res_eq_q;
    logic               res_gt_q;
    logic               res_lt_q;
    logic               res_err_q;

    logic [7:0]         cmp_a_d;
    logic [7:0]         cmp_b_d;
    logic               flags_onehot;
    logic               finish;

    // Comparator pins come straight from the captured operands; zero while idle.
    always_comb begin
        cmp_a_d = 8'h00;
        cmp_b_d = 8'h00;
        if (state_q == CMP) begin
            for (int i = 0; i < WORDS; i++) begin
                if (idx_q == IDXW'(i)) begin
                    cmp_a_d = reg_a_q[8*i +: 8];
                    cmp_b_d = reg_b_q[8*i +: 8];
                end
            end
`ifdef SIGNED_CMP_EN
            // Flipping both sign bits maps signed order onto unsigned order.
            if (idx_q == TOP_IDX) begin
                cmp_a_d[7] = ~cmp_a_d[7];
                cmp_b_d[7] = ~cmp_b_d[7];
            end
`else
`endif
        end
    end

    assign flags_onehot = ({bus.QAEB, bus.QAGB, bus.QASB} == 3'b100) ||
                          ({bus.QAEB, bus.QAGB, bus.QASB} == 3'b010) ||
                          ({bus.QAEB, bus.QAGB, bus.QASB} == 3'b001);

    assign finish = !flags_onehot || bus.QAGB || bus.QASB || (idx_q == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            reg_a_q   <= '0;
            reg_b_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_eq_q  <= 1'b0;
            res_gt_q  <= 1'b0;
            res_lt_q  <= 1'b0;
            res_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        reg_a_q <= bus.OpA;
                        reg_b_q <= bus.OpB;
                        idx_q   <= TOP_IDX;
                        busy_q  <= 1'b1;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    if (finish) begin
                        res_err_q <= !flags_onehot;
                        res_gt_q  <= flags_onehot && bus.QAGB;
                        res_lt_q  <= flags_onehot && bus.QASB;
                        res_eq_q  <= flags_onehot && bus.QAEB;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.ResEQ    = res_eq_q;
    assign bus.ResGT    = res_gt_q;
    assign bus.ResLT    = res_lt_q;
    assign bus.ResErr   = res_err_q;
    assign bus.CmpA     = cmp_a_d;
    assign bus.CmpB     = cmp_b_d;
    assign bus.DbgState = state_q;
endmodule

// File: tb/tb_compare_seq_ctrl.sv
// Directed bench for compare_seq_ctrl (WORDS=4) with a behavioural comparator
// and a queue-based scoreboard checking result code and Start-to-Done latency.
module tb_compare_seq_ctrl;
    localparam int WORDS = 4;
    localparam logic [3:0] R_ERR = 4'b1000;
    localparam logic [3:0] R_EQ  = 4'b0100;
    localparam logic [3:0] R_GT  = 4'b0010;
    localparam logic [3:0] R_LT  = 4'b0001;
`ifdef SIGNED_CMP_EN
    localparam logic [7:0] SFLIP = 8'h80;
`else
    localparam logic [7:0] SFLIP = 8'h00;
`endif

    logic CLK;
    logic RST;
    logic force_bad;

    compare_seq_ctrl_if #(.WORDS(WORDS)) bus ();

    compare_seq_ctrl #(.WORDS(WORDS), .IDXW(4)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Behavioural stand-in for compare_8; force_bad drives all flags low.
    assign bus.QAEB = !force_bad && (bus.CmpA == bus.CmpB);
    assign bus.QAGB = !force_bad && (bus.CmpA >  bus.CmpB);
    assign bus.QASB = !force_bad && (bus.CmpA <  bus.CmpB);

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [11:0] exp_q[$];   // {latency[7:0], result[3:0]}
    int          n_chk;
    int          n_err;
    int          cyc;
    int          start_edge;
    int          done_cnt;
    logic [3:0]  last_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] res_now();
        return {bus.ResErr, bus.ResEQ, bus.ResGT, bus.ResLT};
    endfunction

    // Edge counter; remembers which edge accepted a Start.
    always @(posedge CLK) begin
        cyc++;
        if (!RST && bus.Start && !bus.Busy) start_edge = cyc;
    end

    // Monitor: pops one expectation per Done pulse.
    always @(negedge CLK) begin
        logic [11:0] e;
        if (!RST && bus.Done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_done: got Done=1 expected no Done at edge %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                check("result", {28'd0, res_now()}, {28'd0, e[3:0]});
                check("latency", cyc - start_edge + 1, {24'd0, e[11:4]});
                check("busy_at_done", {31'd0, bus.Busy}, 32'd0);
                last_res = res_now();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (!bus.Busy) return;
            @(negedge CLK);
        end
        check("idle_timeout", {31'd0, bus.Busy}, 32'd0);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 40; i++) begin
            if (done_cnt > d0) return;
            @(negedge CLK);
        end
        check("done_timeout", done_cnt, d0 + 1);
    endtask

    task automatic run_cmp(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] res, input int lat,
                           input bit chk_cmp, input logic [7:0] ca, input logic [7:0] cb);
        int d0;
        @(negedge CLK);
        wait_idle();
        d0 = done_cnt;
        bus.OpA   = a;
        bus.OpB   = b;
        bus.Start = 1'b1;
        exp_q.push_back({lat[7:0], res});
        @(negedge CLK);
        bus.Start = 1'b0;
        check("busy_after_start", {31'd0, bus.Busy}, 32'd1);
        if (chk_cmp) begin
            check("cmp_a_top", {24'd0, bus.CmpA}, {24'd0, ca});
            check("cmp_b_top", {24'd0, bus.CmpB}, {24'd0, cb});
        end
        wait_done(d0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {10'd0, bus.Busy, bus.Done, bus.ResErr, bus.ResEQ, bus.ResGT,
                     bus.ResLT, bus.CmpA, bus.CmpB}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic [3:0]  pr [4];
    int          pl [4];

    initial begin
        int d0;
        n_chk = 0; n_err = 0; cyc = 0; start_edge = 0; done_cnt = 0; last_res = 4'd0;
        force_bad = 1'b0;
        bus.Start = 1'b0;
        bus.OpA   = '0;
        bus.OpB   = '0;
        RST       = 1'b1;
        repeat (3) @(negedge CLK);
        check_all_zero("reset_outputs");
        check("reset_state", {31'd0, bus.DbgState}, 32'd0);
        RST = 1'b0;

        // 1: all bytes equal, full-length walk
        run_cmp(32'h12345678, 32'h12345678, R_EQ, 5, 1'b1, 8'h12 ^ SFLIP, 8'h12 ^ SFLIP);
        // 2: top byte decides; signedness changes the verdict
`ifdef SIGNED_CMP_EN
        run_cmp(32'h80000000, 32'h7FFFFFFF, R_LT, 2, 1'b1, 8'h00, 8'hFF);
`else
        run_cmp(32'h80000000, 32'h7FFFFFFF, R_GT, 2, 1'b1, 8'h80, 8'h7F);
`endif
        // 3: decided at the lowest byte
        run_cmp(32'h00000001, 32'h00000002, R_LT, 5, 1'b0, 8'h00, 8'h00);
        // 4: comparator returns no flag on the first CMP cycle
        force_bad = 1'b1;
        run_cmp(32'hDEADBEEF, 32'hDEADBEEF, R_ERR, 2, 1'b0, 8'h00, 8'h00);
        force_bad = 1'b0;
        // mid-byte decisions after an error result
        run_cmp(32'h00FF0000, 32'h00FE0000, R_GT, 3, 1'b0, 8'h00, 8'h00);
        run_cmp(32'hA5A5_1200, 32'hA5A5_1300, R_LT, 4, 1'b0, 8'h00, 8'h00);

        // 5: Start held high, back-to-back pairs, junk operands while busy
        pa[0] = 32'h00000005; pb[0] = 32'h00000003; pr[0] = R_GT; pl[0] = 5;
        pa[1] = 32'h01000000; pb[1] = 32'h02000000; pr[1] = R_LT; pl[1] = 2;
        pa[2] = 32'hAABBCCDD; pb[2] = 32'hAABBCCDD; pr[2] = R_EQ; pl[2] = 5;
        pa[3] = 32'h00FF0000; pb[3] = 32'h00FE0000; pr[3] = R_GT; pl[3] = 3;
        @(negedge CLK);
        wait_idle();
        d0 = done_cnt;
        bus.Start = 1'b1;
        for (int p = 0; p < 4; p++) begin
            wait_idle();
            bus.OpA = pa[p];
            bus.OpB = pb[p];
            exp_q.push_back({pl[p][7:0], pr[p]});
            @(negedge CLK);
            check("b2b_busy", {31'd0, bus.Busy}, 32'd1);
            check("b2b_res_hold", {28'd0, res_now()}, {28'd0, last_res});
            check("b2b_cmp_a", {24'd0, bus.CmpA}, {24'd0, pa[p][31:24] ^ SFLIP});
            bus.OpA = 32'hFFFFFFFF;
            bus.OpB = 32'h00000000;
        end
        wait_idle();
        bus.Start = 1'b0;
        wait_done(d0 + 3);
        check("b2b_done_count", done_cnt, d0 + 4);

        // 6: reset during the second CMP cycle of an equal compare
        @(negedge CLK);
        wait_idle();
        d0 = done_cnt;
        bus.OpA   = 32'h11223344;
        bus.OpB   = 32'h11223344;
        bus.Start = 1'b1;
        exp_q.push_back({8'd5, R_EQ});
        @(negedge CLK);
        bus.Start = 1'b0;
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 check_all_zero("async_reset_outputs");
        void'(exp_q.pop_front());
        last_res = 4'd0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        check("no_done_after_abort", done_cnt, d0);
        run_cmp(32'h00000010, 32'h00000100, R_LT, 4, 1'b0, 8'h00, 8'h00);

        repeat (3) @(negedge CLK);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_err);
        $finish;
    end
endmodule
